can_eof_ifs_checker: RTL and testbench
======================================

Name: can_eof_ifs_checker

Overview:
- Parametrised successor to the single-channel EOF error checker.
- Checks the End-of-Frame field (EOF_LEN recessive bits) and then the Intermission field (IFS_LEN bits) of a CAN frame.
- Applies the ISO 11898 transmitter/receiver distinction on the last EOF bit, detects overload conditions and a start-of-frame in the last intermission bit, and keeps a saturating EOF error count.
- Sits after the bit-timing/sampling logic and beside the CRC/ACK checkers; its outputs drive the error-frame and overload-frame generators.

Parameters:
- EOF_LEN, 7, EOF field length in bits (legal range 2..64).
- IFS_LEN, 3, intermission length in bits (legal range 2..16).
- CNT_W, 8, width of the saturating EOF error counter.
- IDX_W, $clog2(EOF_LEN), localparam, width of the error bit index.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- sample_pt  in  1  one-clk strobe at the bit sample point; all bus evaluation happens only on cycles with sample_pt=1.
- rx  in  1  sampled bus level (1 = recessive, 0 = dominant).
- eof_start  in  1  qualified by sample_pt; marks the sample of EOF bit 0.
- role_tx  in  1  1 = node is transmitter of this frame; captured when eof_start is qualified.
- cnt_clr  in  1  synchronous clear of err_count.
- eof_error_n  out  1  active-low one-cycle pulse on an EOF form error.
- err_pos  out  IDX_W  index of the EOF bit that failed; held until the next error.
- overload_req  out  1  one-cycle pulse requesting an overload frame.
- sof_detect  out  1  one-cycle pulse: dominant in the last intermission bit.
- frame_done  out  1  one-cycle pulse: intermission completed recessive.
- busy  out  1  1 while in EOF or IFS.
- err_count  out  CNT_W  saturating count of eof_error_n pulses.

Behaviour:
- Reset values: eof_error_n=1, err_pos=0, overload_req=0, sof_detect=0, frame_done=0, busy=0, err_count=0, state=IDLE, bit counter=0.
- Reset asserted mid-field forces all of the above immediately; no pulse is emitted.
- All outputs are registered. A pulse appears in the clk cycle after the qualifying sample_pt cycle and lasts exactly 1 clk.
- Only one of eof_error_n (low), overload_req, sof_detect or frame_done can pulse per sample.
- States: IDLE, EOF, IFS. The bit counter i is $clog2(max(EOF_LEN,IFS_LEN)) bits wide.
- IDLE, on sample_pt & eof_start:
  - Latch role_tx.
  - Evaluate bit 0 using the EOF rule below; if rx=1, go to EOF with i=1.
- EOF, on sample_pt, evaluating bit i:
  - rx=0 and (i<EOF_LEN-1 or role_tx=1): eof_error_n pulse, err_pos=i, err_count+1, go to IDLE.
  - rx=0 and i=EOF_LEN-1 and role_tx=0: overload_req pulse, no error, go to IDLE.
  - rx=1 and i<EOF_LEN-1: i+1.
  - rx=1 and i=EOF_LEN-1: go to IFS, i=0.
- IFS, on sample_pt, evaluating bit i:
  - rx=0 and i<IFS_LEN-1: overload_req pulse, go to IDLE.
  - rx=0 and i=IFS_LEN-1: sof_detect pulse, go to IDLE.
  - rx=1 and i=IFS_LEN-1: frame_done pulse, go to IDLE.
  - Otherwise: i+1.
- eof_start qualified while in EOF or IFS: abort the current field silently (no pulse) and restart at bit 0 with a freshly latched role_tx.
- sample_pt=0: state, counter and outputs hold (pulse outputs return to their inactive value).
- err_count saturates at 2^CNT_W-1 and does not wrap. If cnt_clr and an increment coincide, the clear wins and the increment is lost.
- busy = (state != IDLE), registered.

Decomposition:
- Package can_frame_pkg:
  - state enum {IDLE, EOF, IFS}.
  - Constants RECESSIVE=1'b1 and DOMINANT=1'b0.
  - Default EOF_LEN=7 and IFS_LEN=3.
- Sub-module can_sat_counter (parameter W; ports inc, clr, count) implements err_count; it is reused by the CRC and ACK checkers.

Test Plan:
- Defaults, role_tx=0, 7 recessive EOF bits then 3 recessive IFS bits -> exactly one frame_done pulse after the 10th sample, no error, busy=0 afterwards.
- role_tx=0, dominant on EOF bit 3 -> eof_error_n low for 1 clk, err_pos=3, err_count=1, state IDLE.
- Dominant on EOF bit 6:
  - with role_tx=0 -> overload_req pulse, err_count unchanged.
  - with role_tx=1 -> eof_error_n pulse, err_pos=6.
- Clean EOF then IFS dominant on bit 1 -> overload_req pulse; separately, dominant on IFS bit 2 -> sof_detect pulse only.
- CNT_W=2, 5 consecutive bit-0 errors -> err_count reads 1, 2, 3, 3, 3. cnt_clr coincident with the 5th error -> err_count=0.
- Reset asserted asynchronously at EOF bit 4 -> outputs at reset values before the next clk edge. A new eof_start issued while in IFS bit 1 restarts the check with no pulse emitted.

Source files
------------

// File: rtl/can_frame_pkg.sv
// Shared CAN frame-field definitions for the EOF/IFS, CRC and ACK checkers.
package can_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EOF  = 2'd1,
    IFS  = 2'd2
  } can_state_e;

  localparam logic RECESSIVE = 1'b1;
  localparam logic DOMINANT  = 1'b0;

  localparam int unsigned EOF_LEN_DEF = 7;
  localparam int unsigned IFS_LEN_DEF = 3;

endpackage

// File: rtl/can_sat_counter.sv
// Saturating event counter with synchronous clear; the clear beats an increment.
module can_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_CNT = '1;

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear first, otherwise increment unless already saturated.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != MAX_CNT)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/can_eof_ifs_checker.sv
// End-of-Frame and Intermission checker: form errors, overload requests,
// early SOF detection and a saturating EOF error count.
module can_eof_ifs_checker
  import can_frame_pkg::*;
#(
  parameter  int unsigned EOF_LEN = EOF_LEN_DEF,
  parameter  int unsigned IFS_LEN = IFS_LEN_DEF,
  parameter  int unsigned CNT_W   = 8,
  localparam int unsigned IDX_W   = $clog2(EOF_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_pt,
  input  logic             rx,
  input  logic             eof_start,
  input  logic             role_tx,
  input  logic             cnt_clr,
  output logic             eof_error_n,
  output logic [IDX_W-1:0] err_pos,
  output logic             overload_req,
  output logic             sof_detect,
  output logic             frame_done,
  output logic             busy,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned MAX_LEN = (EOF_LEN > IFS_LEN) ? EOF_LEN : IFS_LEN;
  localparam int unsigned BIT_W   = $clog2(MAX_LEN);

  localparam logic [BIT_W-1:0] EOF_LAST = BIT_W'(EOF_LEN - 1);
  localparam logic [BIT_W-1:0] IFS_LAST = BIT_W'(IFS_LEN - 1);

  can_state_e       state_q;
  logic [BIT_W-1:0] bit_q;
  logic             role_q;
  logic             eof_error_n_q;
  logic [IDX_W-1:0] err_pos_q;
  logic             overload_q;
  logic             sof_q;
  logic             done_q;
  logic             busy_q;
  logic             err_inc_c;

  // EOF form error on this sample; bit 0 is never the last EOF bit, so role is irrelevant there.
  always_comb begin
    err_inc_c = 1'b0;
    if (sample_pt) begin
      if (eof_start) begin
        err_inc_c = (rx == DOMINANT);
      end else if (state_q == EOF) begin
        err_inc_c = (rx == DOMINANT) && ((bit_q != EOF_LAST) || role_q);
      end
    end
  end

  // Field sequencer with registered pulse outputs; a qualified eof_start always restarts at bit 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      bit_q         <= '0;
      role_q        <= 1'b0;
      eof_error_n_q <= 1'b1;
      err_pos_q     <= '0;
      overload_q    <= 1'b0;
      sof_q         <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      eof_error_n_q <= 1'b1;
      overload_q    <= 1'b0;
      sof_q         <= 1'b0;
      done_q        <= 1'b0;
      if (sample_pt) begin
        if (eof_start) begin
          role_q <= role_tx;
          if (rx == RECESSIVE) begin
            state_q <= EOF;
            bit_q   <= BIT_W'(1);
            busy_q  <= 1'b1;
          end else begin
            eof_error_n_q <= 1'b0;
            err_pos_q     <= '0;
            state_q       <= IDLE;
            bit_q         <= '0;
            busy_q        <= 1'b0;
          end
        end else begin
          case (state_q)
            EOF: begin
              if (rx == DOMINANT) begin
                if (err_inc_c) begin
                  eof_error_n_q <= 1'b0;
                  err_pos_q     <= IDX_W'(bit_q);
                end else begin
                  overload_q <= 1'b1;
                end
                state_q <= IDLE;
                bit_q   <= '0;
                busy_q  <= 1'b0;
              end else if (bit_q == EOF_LAST) begin
                state_q <= IFS;
                bit_q   <= '0;
              end else begin
                bit_q <= bit_q + BIT_W'(1);
              end
            end
            IFS: begin
              if (rx == DOMINANT) begin
                if (bit_q == IFS_LAST) begin
                  sof_q <= 1'b1;
                end else begin
                  overload_q <= 1'b1;
                end
                state_q <= IDLE;
                bit_q   <= '0;
                busy_q  <= 1'b0;
              end else if (bit_q == IFS_LAST) begin
                done_q  <= 1'b1;
                state_q <= IDLE;
                bit_q   <= '0;
                busy_q  <= 1'b0;
              end else begin
                bit_q <= bit_q + BIT_W'(1);
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  can_sat_counter #(
    .W(CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (err_inc_c),
    .clr  (cnt_clr),
    .count(err_count)
  );

  assign eof_error_n  = eof_error_n_q;
  assign err_pos      = err_pos_q;
  assign overload_req = overload_q;
  assign sof_detect   = sof_q;
  assign frame_done   = done_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_can_eof_ifs_checker.sv
// Bench for can_eof_ifs_checker: a default instance and a short-field 2-bit-counter
// instance share one stimulus stream and are compared every cycle to a sequence model.
module tb_can_eof_ifs_checker;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sample_pt = 1'b0;
  logic rx = 1'b1;
  logic eof_start = 1'b0;
  logic role_tx = 1'b0;
  logic cnt_clr = 1'b0;

  logic       d1_err_n, d1_ovl, d1_sof, d1_done, d1_busy;
  logic [2:0] d1_pos;
  logic [7:0] d1_cnt;
  logic       d2_err_n, d2_ovl, d2_sof, d2_done, d2_busy;
  logic [1:0] d2_pos;
  logic [1:0] d2_cnt;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  can_eof_ifs_checker dut1 (
    .clk(clk), .reset(reset), .sample_pt(sample_pt), .rx(rx), .eof_start(eof_start),
    .role_tx(role_tx), .cnt_clr(cnt_clr), .eof_error_n(d1_err_n), .err_pos(d1_pos),
    .overload_req(d1_ovl), .sof_detect(d1_sof), .frame_done(d1_done), .busy(d1_busy),
    .err_count(d1_cnt)
  );

  can_eof_ifs_checker #(.EOF_LEN(4), .IFS_LEN(2), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .sample_pt(sample_pt), .rx(rx), .eof_start(eof_start),
    .role_tx(role_tx), .cnt_clr(cnt_clr), .eof_error_n(d2_err_n), .err_pos(d2_pos),
    .overload_req(d2_ovl), .sof_detect(d2_sof), .frame_done(d2_done), .busy(d2_busy),
    .err_count(d2_cnt)
  );

  // Model: position k counts through the EOF+IFS bit sequence of each instance.
  int E[2]  = '{7, 4};
  int I[2]  = '{3, 2};
  int MX[2] = '{255, 3};
  bit m_act[2], m_role[2], m_err[2], m_ovl[2], m_sof[2], m_done[2];
  int m_k[2], m_cnt[2], m_pos[2];

  task automatic model_step(input int n);
    int j;
    m_err[n] = 0; m_ovl[n] = 0; m_sof[n] = 0; m_done[n] = 0;
    if (sample_pt) begin
      if (eof_start) begin
        m_act[n] = 1; m_role[n] = role_tx; m_k[n] = 0;
      end
      if (m_act[n]) begin
        if (m_k[n] < E[n]) begin
          if (!rx) begin
            if (m_k[n] < E[n] - 1 || m_role[n]) begin
              m_err[n] = 1; m_pos[n] = m_k[n];
            end else begin
              m_ovl[n] = 1;
            end
            m_act[n] = 0;
          end else begin
            m_k[n]++;
          end
        end else begin
          j = m_k[n] - E[n];
          if (!rx) begin
            if (j < I[n] - 1) m_ovl[n] = 1;
            else m_sof[n] = 1;
            m_act[n] = 0;
          end else if (j == I[n] - 1) begin
            m_done[n] = 1; m_act[n] = 0;
          end else begin
            m_k[n]++;
          end
        end
      end
    end
    if (cnt_clr) m_cnt[n] = 0;
    else if (m_err[n] && m_cnt[n] < MX[n]) m_cnt[n]++;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < 2; n++) begin
        m_act[n] = 0; m_role[n] = 0; m_k[n] = 0; m_cnt[n] = 0; m_pos[n] = 0;
        m_err[n] = 0; m_ovl[n] = 0; m_sof[n] = 0; m_done[n] = 0;
      end
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic cmp_inst(input int n, input int en, input int pos, input int ovl,
                          input int sof, input int dn, input int bsy, input int cnt);
    int x_en, x_bsy;
    x_en  = m_err[n] ? 0 : 1;
    x_bsy = m_act[n] ? 1 : 0;
    tot_cnt++;
    if (en == x_en && pos == m_pos[n] && ovl == int'(m_ovl[n]) && sof == int'(m_sof[n]) &&
        dn == int'(m_done[n]) && bsy == x_bsy && cnt == m_cnt[n]) begin
      pass_cnt++;
    end else begin
      $display("FAIL model_cmp dut%0d t=%0t got en=%0d pos=%0d ovl=%0d sof=%0d done=%0d busy=%0d cnt=%0d expected en=%0d pos=%0d ovl=%0d sof=%0d done=%0d busy=%0d cnt=%0d",
               n + 1, $time, en, pos, ovl, sof, dn, bsy, cnt,
               x_en, m_pos[n], m_ovl[n], m_sof[n], m_done[n], x_bsy, m_cnt[n]);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0, int'(d1_err_n), int'(d1_pos), int'(d1_ovl), int'(d1_sof), int'(d1_done),
               int'(d1_busy), int'(d1_cnt));
      cmp_inst(1, int'(d2_err_n), int'(d2_pos), int'(d2_ovl), int'(d2_sof), int'(d2_done),
               int'(d2_busy), int'(d2_cnt));
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic samp(input bit rxv, input bit st, input bit rl, input bit clr);
    @(negedge clk);
    rx = rxv; eof_start = st; role_tx = rl; cnt_clr = clr; sample_pt = 1'b1;
    @(negedge clk);
    sample_pt = 1'b0; eof_start = 1'b0; cnt_clr = 1'b0; rx = 1'b1;
  endtask

  task automatic ones(input int n);
    for (int b = 0; b < n; b++) samp(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  int sat_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_err_n", int'(d1_err_n), 1);
    chk("reset_busy", int'(d1_busy), 0);
    chk("reset_cnt", int'(d1_cnt), 0);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    // Clean frame: 7 EOF + 3 IFS recessive samples
    samp(1'b1, 1'b1, 1'b0, 1'b0);
    ones(8);
    chk("clean_busy_before_last", int'(d1_busy), 1);
    chk("clean_done_early", int'(d1_done), 0);
    samp(1'b1, 1'b0, 1'b0, 1'b0);
    chk("clean_done", int'(d1_done), 1);
    chk("clean_no_err", int'(d1_err_n), 1);
    @(negedge clk);
    chk("clean_done_1clk", int'(d1_done), 0);
    chk("clean_busy_after", int'(d1_busy), 0);

    // Dominant at EOF bit 3, receiver
    samp(1'b1, 1'b1, 1'b0, 1'b0);
    ones(2);
    samp(1'b0, 1'b0, 1'b0, 1'b0);
    chk("bit3_err_n", int'(d1_err_n), 0);
    chk("bit3_pos", int'(d1_pos), 3);
    chk("bit3_cnt", int'(d1_cnt), 1);
    chk("bit3_busy", int'(d1_busy), 0);
    @(negedge clk);
    chk("bit3_err_n_1clk", int'(d1_err_n), 1);

    // Dominant at last EOF bit: receiver -> overload, transmitter -> error
    samp(1'b1, 1'b1, 1'b0, 1'b0);
    ones(5);
    samp(1'b0, 1'b0, 1'b0, 1'b0);
    chk("bit6_rx_ovl", int'(d1_ovl), 1);
    chk("bit6_rx_no_err", int'(d1_err_n), 1);
    chk("bit6_rx_cnt", int'(d1_cnt), 1);
    samp(1'b1, 1'b1, 1'b1, 1'b0);
    ones(5);
    samp(1'b0, 1'b0, 1'b0, 1'b0);
    chk("bit6_tx_err_n", int'(d1_err_n), 0);
    chk("bit6_tx_pos", int'(d1_pos), 6);
    chk("bit6_tx_cnt", int'(d1_cnt), 2);

    // IFS dominant on bit 1 -> overload; on bit 2 -> SOF
    samp(1'b1, 1'b1, 1'b0, 1'b0);
    ones(7);
    samp(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ifs1_ovl", int'(d1_ovl), 1);
    chk("ifs1_sof", int'(d1_sof), 0);
    samp(1'b1, 1'b1, 1'b0, 1'b0);
    ones(8);
    samp(1'b0, 1'b0, 1'b0, 1'b0);
    chk("ifs2_sof", int'(d1_sof), 1);
    chk("ifs2_ovl", int'(d1_ovl), 0);
    chk("ifs2_err_n", int'(d1_err_n), 1);
    chk("ifs2_done", int'(d1_done), 0);

    // 2-bit counter saturation on repeated bit-0 errors
    samp(1'b1, 1'b0, 1'b0, 1'b1);
    for (int e = 0; e < 5; e++) begin
      samp(1'b0, 1'b1, 1'b0, 1'b0);
      chk("sat_cnt", int'(d2_cnt), sat_exp[e]);
    end
    chk("sat_wide_cnt", int'(d1_cnt), 5);
    samp(1'b1, 1'b0, 1'b0, 1'b1);
    for (int e = 0; e < 4; e++) samp(1'b0, 1'b1, 1'b0, 1'b0);
    samp(1'b0, 1'b1, 1'b0, 1'b1);
    chk("clr_wins_cnt", int'(d2_cnt), 0);
    chk("clr_wins_wide_cnt", int'(d1_cnt), 0);
    chk("clr_wins_err_n", int'(d1_err_n), 0);

    // Async reset while in EOF bit 4
    samp(1'b1, 1'b1, 1'b0, 1'b0);
    ones(1);
    samp(1'b0, 1'b0, 1'b0, 1'b0);
    samp(1'b1, 1'b1, 1'b0, 1'b0);
    ones(3);
    @(negedge clk);
    rx = 1'b1; sample_pt = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", int'(d1_busy), 0);
    chk("arst_pos", int'(d1_pos), 0);
    chk("arst_cnt", int'(d1_cnt), 0);
    chk("arst_err_n", int'(d1_err_n), 1);
    @(negedge clk);
    sample_pt = 1'b0;
    #1 reset = 1'b0;

    // Restart by eof_start inside IFS bit 1
    samp(1'b1, 1'b1, 1'b0, 1'b0);
    ones(7);
    samp(1'b1, 1'b1, 1'b1, 1'b0);
    chk("restart_no_err", int'(d1_err_n), 1);
    chk("restart_no_ovl", int'(d1_ovl), 0);
    chk("restart_no_done", int'(d1_done), 0);
    chk("restart_busy", int'(d1_busy), 1);
    ones(8);
    samp(1'b1, 1'b0, 1'b0, 1'b0);
    chk("restart_done", int'(d1_done), 1);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      sample_pt = ($urandom_range(0, 2) == 0);
      rx        = ($urandom_range(0, 19) != 0);
      eof_start = ($urandom_range(0, 11) == 0);
      role_tx   = 1'($urandom_range(0, 1));
      cnt_clr   = ($urandom_range(0, 59) == 0);
    end
    @(negedge clk);
    sample_pt = 1'b0; eof_start = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
